// File: rtl/pcache_multi.sv
// Primitive parameter cache: per-tag header + vertex fields in per-field RAMs,
// with valid tracking, masked writes, write-to-read forwarding, flush and occupancy count.
module pcache_multi #(
    parameter int ENTRIES    = 512,
    parameter int TAG_W      = 12,
    parameter int WORD_W     = 32,
    parameter int HDR_FIELDS = 3,
    parameter int VERTS      = 3,
    parameter int VFIELDS    = 7,
    localparam int FIELDS    = HDR_FIELDS + VERTS * VFIELDS,
    localparam int CNT_W     = $clog2(ENTRIES + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [TAG_W-1:0]         wr_tag,
    input  logic [FIELDS-1:0]        wr_mask,
    input  logic [FIELDS*WORD_W-1:0] wr_data,
    input  logic                     rd_en,
    input  logic [TAG_W-1:0]         rd_tag,
    output logic                     rd_valid,
    output logic                     rd_hit,
    output logic [FIELDS*WORD_W-1:0] rd_data,
    output logic [CNT_W-1:0]         count
);

    localparam int AW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [TAG_W:0] LIMIT = (TAG_W + 1)'(ENTRIES);

    logic               wr_ok;
    logic               rd_ok;
    logic               fwd;
    logic [AW-1:0]      wr_idx;
    logic [AW-1:0]      rd_idx;
    logic [ENTRIES-1:0] valid;

    assign wr_ok  = wr_en && ({1'b0, wr_tag} < LIMIT);
    assign rd_ok  = {1'b0, rd_tag} < LIMIT;
    assign wr_idx = wr_tag[AW-1:0];
    assign rd_idx = rd_tag[AW-1:0];
    assign fwd    = wr_ok && rd_en && rd_ok && (wr_tag == rd_tag);

    // Flush clears first; a same-cycle write then re-marks its own entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= '0;
            count <= '0;
        end else begin
            if (flush)
                valid <= '0;
            if (wr_ok)
                valid[wr_idx] <= 1'b1;
            if (flush)
                count <= wr_ok ? CNT_W'(1) : '0;
            else if (wr_ok && !valid[wr_idx])
                count <= count + CNT_W'(1);
        end
    end

    // Hit is judged on the pre-flush valid bit, or on a forwarded write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_hit   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_hit <= rd_ok && (valid[rd_idx] || fwd);
        end
    end

    for (genvar i = 0; i < FIELDS; i++) begin : g_field
        logic [WORD_W-1:0] mem [ENTRIES];
        logic [WORD_W-1:0] q;

        always_ff @(posedge clock) begin
            if (wr_ok && wr_mask[i])
                mem[wr_idx] <= wr_data[i*WORD_W +: WORD_W];
        end

        // mem is read before the same-edge write lands, so unmasked fields return old contents.
        always_ff @(posedge clock or posedge reset) begin
            if (reset)
                q <= '0;
            else if (rd_en) begin
                if (!rd_ok)
                    q <= '0;
                else if (fwd && wr_mask[i])
                    q <= wr_data[i*WORD_W +: WORD_W];
                else
                    q <= mem[rd_idx];
            end
        end

        assign rd_data[i*WORD_W +: WORD_W] = q;
    end

endmodule

// File: tb/tb_pcache_multi.sv
// Directed bench for pcache_multi: a tag-indexed reference model predicts every
// output each cycle; literal expectations pin key results of the test plan.
module tb_pcache_multi;

    localparam int E  = 512;
    localparam int TW = 12;
    localparam int W  = 32;
    localparam int F  = 24;
    localparam int DW = F * W;
    localparam int CW = 10;

    logic          clock   = 1'b0;
    logic          reset   = 1'b0;
    logic          flush   = 1'b0;
    logic          wr_en   = 1'b0;
    logic [TW-1:0] wr_tag  = '0;
    logic [F-1:0]  wr_mask = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en   = 1'b0;
    logic [TW-1:0] rd_tag  = '0;
    logic          rd_valid;
    logic          rd_hit;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] count;

    pcache_multi #(
        .ENTRIES(E), .TAG_W(TW), .WORD_W(W),
        .HDR_FIELDS(3), .VERTS(3), .VFIELDS(7)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .wr_en(wr_en), .wr_tag(wr_tag), .wr_mask(wr_mask), .wr_data(wr_data),
        .rd_en(rd_en), .rd_tag(rd_tag),
        .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_data(rd_data), .count(count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 0;

    // Reference state: contents per tag/field, whether each word is defined, valid per tag.
    logic [W-1:0] m_mem   [E][F];
    bit           m_known [E][F];
    bit           m_valid [E];

    // Outputs expected after the coming edge (nxt) and during the current cycle (exp).
    bit           nxt_rv, exp_rv;
    bit           nxt_hit, exp_hit;
    logic [W-1:0] nxt_data [F];
    logic [W-1:0] exp_data [F];
    bit           nxt_known [F];
    bit           exp_known [F];
    int           nxt_cnt, exp_cnt;

    logic [DW-1:0] cmp_ev, cmp_km;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic logic [W-1:0] fld(input int i);
        return rd_data[i*W +: W];
    endfunction

    task automatic set_field(input int i, input logic [W-1:0] v);
        wr_data[i*W +: W] = v;
    endtask

    task automatic predict();
        int unsigned rt, wt;
        bit win, rin, fwd;
        rt  = rd_tag;
        wt  = wr_tag;
        win = wr_en && (wt < E);
        rin = rt < E;
        fwd = win && rd_en && rin && (wt == rt);
        if (rd_en) begin
            nxt_rv = 1;
            if (!rin) begin
                nxt_hit = 0;
                for (int i = 0; i < F; i++) begin
                    nxt_data[i]  = '0;
                    nxt_known[i] = 1;
                end
            end else begin
                nxt_hit = m_valid[rt] || fwd;
                for (int i = 0; i < F; i++) begin
                    if (fwd && wr_mask[i]) begin
                        nxt_data[i]  = wr_data[i*W +: W];
                        nxt_known[i] = 1;
                    end else begin
                        nxt_data[i]  = m_mem[rt][i];
                        nxt_known[i] = m_known[rt][i];
                    end
                end
            end
        end else begin
            nxt_rv = 0;
        end
        if (flush)
            for (int t = 0; t < E; t++) m_valid[t] = 0;
        if (win) begin
            for (int i = 0; i < F; i++)
                if (wr_mask[i]) begin
                    m_mem[wt][i]   = wr_data[i*W +: W];
                    m_known[wt][i] = 1;
                end
            m_valid[wt] = 1;
        end
        nxt_cnt = 0;
        for (int t = 0; t < E; t++) nxt_cnt += int'(m_valid[t]);
    endtask

    task automatic step(input bit fl, input bit we, input int unsigned wt, input logic [F-1:0] wm,
                        input bit re, input int unsigned rt);
        flush   = fl;
        wr_en   = we;
        wr_tag  = TW'(wt);
        wr_mask = wm;
        rd_en   = re;
        rd_tag  = TW'(rt);
        predict();
        @(posedge clock);
        exp_rv    = nxt_rv;
        exp_hit   = nxt_hit;
        exp_data  = nxt_data;
        exp_known = nxt_known;
        exp_cnt   = nxt_cnt;
        #1;
        flush = 0;
        wr_en = 0;
        rd_en = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, '0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1;
        flush = 0;
        wr_en = 0;
        rd_en = 0;
        for (int t = 0; t < E; t++) begin
            m_valid[t] = 0;
            for (int i = 0; i < F; i++) m_known[t][i] = 0;
        end
        nxt_rv  = 0;
        nxt_hit = 0;
        nxt_cnt = 0;
        for (int i = 0; i < F; i++) begin
            nxt_data[i]  = '0;
            nxt_known[i] = 1;
        end
        exp_rv    = nxt_rv;
        exp_hit   = nxt_hit;
        exp_data  = nxt_data;
        exp_known = nxt_known;
        exp_cnt   = nxt_cnt;
        armed = 1;
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
    endtask

    always @(negedge clock) begin
        if (armed) begin
            for (int i = 0; i < F; i++) begin
                cmp_ev[i*W +: W] = exp_data[i];
                cmp_km[i*W +: W] = exp_known[i] ? {W{1'b1}} : {W{1'b0}};
            end
            chk("model_rd_valid", DW'(rd_valid), DW'(exp_rv));
            chk("model_count", DW'(count), DW'(exp_cnt));
            chk("model_rd_data", rd_data & cmp_km, cmp_ev & cmp_km);
            if (exp_rv)
                chk("model_rd_hit", DW'(rd_hit), DW'(exp_hit));
        end
    end

    initial begin
        do_reset();
        chk("reset_rd_valid", DW'(rd_valid), 0);
        chk("reset_rd_hit", DW'(rd_hit), 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_count", DW'(count), 0);

        // Full write of tag 5, read it back next cycle.
        for (int i = 0; i < F; i++) set_field(i, W'(32'h01010101 * i));
        set_field(0, 32'h11111111);
        set_field(23, 32'hDEADBEEF);
        step(0, 1, 5, '1, 0, 0);
        step(0, 0, 0, '0, 1, 5);
        chk("t5_rd_valid", DW'(rd_valid), 1);
        chk("t5_rd_hit", DW'(rd_hit), 1);
        chk("t5_field0", DW'(fld(0)), 32'h11111111);
        chk("t5_field23", DW'(fld(23)), 32'hDEADBEEF);
        chk("t5_count", DW'(count), 1);

        // Miss, out-of-range read and write.
        step(0, 0, 0, '0, 1, 7);
        chk("t7_rd_valid", DW'(rd_valid), 1);
        chk("t7_rd_hit", DW'(rd_hit), 0);
        step(0, 0, 0, '0, 1, 600);
        chk("t600_rd_hit", DW'(rd_hit), 0);
        chk("t600_rd_data", rd_data, 0);
        step(0, 1, 600, '1, 0, 0);
        idle();
        chk("t600_wr_count", DW'(count), 1);

        // Masked write with same-cycle forwarding.
        set_field(0, 32'h0A);
        set_field(1, 32'h0B);
        step(0, 1, 3, 24'h3, 0, 0);
        set_field(0, 32'hFF);
        set_field(1, 32'h0C);
        step(0, 1, 3, 24'h2, 1, 3);
        chk("fwd_field0", DW'(fld(0)), 32'h0A);
        chk("fwd_field1", DW'(fld(1)), 32'h0C);
        chk("fwd_rd_hit", DW'(rd_hit), 1);
        step(0, 0, 0, '0, 1, 3);
        chk("reread_field0", DW'(fld(0)), 32'h0A);
        chk("reread_field1", DW'(fld(1)), 32'h0C);
        chk("reread_rd_hit", DW'(rd_hit), 1);
        chk("t3_count", DW'(count), 2);

        // Fill every entry, rewrite, flush, and confirm all reads miss.
        for (int t = 0; t < E; t++) begin
            set_field(0, W'(t));
            step(0, 1, t, '1, 0, 0);
        end
        chk("full_count", DW'(count), 512);
        step(0, 1, 0, '1, 0, 0);
        chk("rewrite_count", DW'(count), 512);
        step(1, 0, 0, '0, 0, 0);
        chk("flush_count", DW'(count), 0);
        for (int t = 0; t < E; t++) step(0, 0, 0, '0, 1, t);
        chk("post_flush_hit", DW'(rd_hit), 0);

        // Flush combined with write, then with read.
        step(1, 1, 9, '1, 0, 0);
        chk("flush_wr_count", DW'(count), 1);
        step(0, 0, 0, '0, 1, 9);
        chk("flush_wr_hit", DW'(rd_hit), 1);
        step(0, 1, 4, '1, 0, 0);
        chk("t4_count", DW'(count), 2);
        step(1, 0, 0, '0, 1, 4);
        chk("flush_rd_hit", DW'(rd_hit), 1);
        chk("flush_rd_count", DW'(count), 0);
        step(0, 0, 0, '0, 1, 4);
        chk("after_flush_rd_hit", DW'(rd_hit), 0);

        // Reset while a read result is pending.
        step(0, 0, 0, '0, 1, 1);
        do_reset();
        chk("midrd_rd_valid", DW'(rd_valid), 0);
        chk("midrd_rd_hit", DW'(rd_hit), 0);
        chk("midrd_rd_data", rd_data, 0);
        chk("midrd_count", DW'(count), 0);

        // Back-to-back reads return in order.
        for (int t = 1; t <= 3; t++) begin
            set_field(0, W'(32'h100 + t));
            step(0, 1, t, '1, 0, 0);
        end
        for (int t = 1; t <= 3; t++) begin
            step(0, 0, 0, '0, 1, t);
            chk("b2b_rd_valid", DW'(rd_valid), 1);
            chk("b2b_rd_hit", DW'(rd_hit), 1);
            chk("b2b_field0", DW'(fld(0)), DW'(32'h100 + t));
        end
        idle();
        chk("b2b_idle_rd_valid", DW'(rd_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
